// File: rtl/utopia_phy_cell_source.sv
// Purpose: PHY-side Utopia L1 Rx cell source; buffers whole ATM cells from a byte stream, inserts HEC, sends octets.
// Latency: a cell becomes claimable one clock after its last byte is accepted; an enabled edge loads one octet onto rx_data.
// Backpressure: in_ready drops when every slot is committed or being sent; rx_en_n high freezes the transmit side.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   in_valid/in_sop/in_data/in_ready   byte-stream write side (in_sop marks byte 0)
//   rx_en_n/rx_data/rx_soc/rx_clav     Utopia Rx side (RxEnb*, RxData, RxSOC, RxClav)
//   cells_avail        complete cells not yet claimed by the transmitter
//   drop_pulse         one-cycle flag: a stray byte or an unfinished cell was thrown away
module utopia_phy_cell_source #(
  parameter int CELL_BYTES  = 53,
  parameter int DEPTH_CELLS = 4,
  parameter bit GEN_HEC     = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic                             in_sop,
  input  logic [7:0]                       in_data,
  output logic                             in_ready,
  input  logic                             rx_en_n,
  output logic [7:0]                       rx_data,
  output logic                             rx_soc,
  output logic                             rx_clav,
  output logic [$clog2(DEPTH_CELLS+1)-1:0] cells_avail,
  output logic                             drop_pulse
);

  localparam int SW = $clog2(DEPTH_CELLS);
  localparam int IW = $clog2(CELL_BYTES);
  localparam int CW = $clog2(DEPTH_CELLS + 1);
  localparam int AW = $clog2(DEPTH_CELLS * CELL_BYTES);
  localparam logic [IW-1:0] LAST    = IW'(CELL_BYTES - 1);
  localparam logic [IW-1:0] HEC_IDX = IW'(4);
  localparam logic [CW:0]   DEPTH_V = (CW+1)'(DEPTH_CELLS);

  // One step of CRC-8, polynomial x^8+x^2+x+1, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  typedef enum logic {IDLE, SEND} state_t;

  logic [7:0]    mem [DEPTH_CELLS*CELL_BYTES];

  // write side
  logic          wr_open;
  logic [SW-1:0] wr_slot;
  logic [IW-1:0] wr_idx;
  logic [7:0]    crc;
  logic          accept, commit, wr_en;
  logic [IW-1:0] wr_pos;
  logic [7:0]    wr_byte;
  logic [AW-1:0] wr_addr;

  // read side
  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          hold, hold_n;      // slot still owned by the transmitter
  logic [SW-1:0] rd_slot, rd_slot_n;
  logic [7:0]    rx_data_n;
  logic          rx_soc_n;
  logic          claim;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_byte;
  logic [CW:0]   occupied;

  // The slot being filled is not counted: it was reserved when its first byte
  // was accepted, so the cell in progress can always be finished.
  assign occupied = {1'b0, cells_avail} + {{CW{1'b0}}, hold};
  assign in_ready = wr_open | (occupied < DEPTH_V);
  assign rx_clav  = (cells_avail != '0);

  always_comb begin
    accept  = in_valid & in_ready;
    wr_en   = accept & (in_sop | wr_open);
    wr_pos  = in_sop ? '0 : wr_idx;
    commit  = accept & ~in_sop & wr_open & (wr_idx == LAST);
    wr_byte = in_data;
    if (GEN_HEC && !in_sop && wr_idx == HEC_IDX) begin
      wr_byte = crc ^ 8'h55;
    end
    wr_addr = AW'(wr_slot) * AW'(CELL_BYTES) + AW'(wr_pos);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_open    <= 1'b0;
      wr_slot    <= '0;
      wr_idx     <= '0;
      crc        <= '0;
      drop_pulse <= 1'b0;
    end else begin
      // sop over an open cell abandons it; a non-sop byte with no open cell is stray
      drop_pulse <= accept & (in_sop ? wr_open : ~wr_open);
      if (accept) begin
        if (in_sop) begin
          wr_open <= 1'b1;
          wr_idx  <= IW'(1);
          crc     <= crc8_step(8'h00, in_data);
        end else if (wr_open) begin
          if (wr_idx < HEC_IDX) begin
            crc <= crc8_step(crc, in_data);
          end
          if (wr_idx == LAST) begin
            wr_open <= 1'b0;
            wr_idx  <= '0;
            wr_slot <= wr_slot + 1'b1;
          end else begin
            wr_idx <= wr_idx + 1'b1;
          end
        end
      end
    end
  end

  // idx is zero whenever no slot is held, so rd_addr then points at byte 0 of
  // the oldest committed cell, ready for a claim.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    hold_n    = hold;
    rd_slot_n = rd_slot;
    rx_data_n = rx_data;
    rx_soc_n  = rx_soc;
    claim     = 1'b0;
    rd_addr   = AW'(rd_slot) * AW'(CELL_BYTES) + AW'(idx);
    rd_byte   = mem[rd_addr];
    case (state)
      IDLE: begin
        if (!rx_en_n) begin
          if (cells_avail != '0) begin
            claim     = 1'b1;
            rx_data_n = rd_byte;
            rx_soc_n  = 1'b1;
            idx_n     = IW'(1);
            hold_n    = 1'b1;
            state_n   = SEND;
          end else begin
            rx_soc_n = 1'b0;
          end
        end
      end
      SEND: begin
        if (!rx_en_n) begin
          if (hold) begin
            rx_data_n = rd_byte;
            rx_soc_n  = 1'b0;
            if (idx == LAST) begin
              hold_n    = 1'b0;
              idx_n     = '0;
              rd_slot_n = rd_slot + 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else if (cells_avail != '0) begin
            claim     = 1'b1;
            rx_data_n = rd_byte;
            rx_soc_n  = 1'b1;
            idx_n     = IW'(1);
            hold_n    = 1'b1;
          end else begin
            rx_soc_n = 1'b0;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      hold        <= 1'b0;
      rd_slot     <= '0;
      rx_data     <= '0;
      rx_soc      <= 1'b0;
      cells_avail <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      hold        <= hold_n;
      rd_slot     <= rd_slot_n;
      rx_data     <= rx_data_n;
      rx_soc      <= rx_soc_n;
      cells_avail <= cells_avail + CW'(commit) - CW'(claim);
    end
  end

endmodule
